// File: rtl/regfile_pkg.sv
// Shared register-file constants: default widths and writeback requester IDs.
package regfile_pkg;

    localparam int RF_WIDTH   = 32;
    localparam int RF_DEPTH   = 5;
    localparam int WB_N_REQ   = 3;

    localparam int WB_ALU     = 0;
    localparam int WB_LOAD    = 1;
    localparam int WB_MULDIV  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer,
// pointer moves past the winner whenever advance is asserted.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] win_idx;
    logic          found;

    always_comb begin
        grant_o  = '0;
        found    = 1'b0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[scan_idx]) begin
                grant_o[scan_idx] = 1'b1;
                found             = 1'b1;
                win_idx           = scan_idx;
            end
            scan_idx = (scan_idx == PW'(N - 1)) ? '0 : scan_idx + 1'b1;
        end
        // Nothing may be acknowledged while the block is held in reset.
        if (reset) begin
            grant_o = '0;
            found   = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/register_writeback_arbiter.sv
// Shares the register file write port among writeback units and tracks pending
// destination registers in a busy scoreboard for decode hazard checks.
module register_writeback_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int N_REQ = WB_N_REQ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*DEPTH-1:0] req_index,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic                   reserve_valid,
    input  logic [DEPTH-1:0]       reserve_index,
    output logic                   reserve_ready,
    input  logic [DEPTH-1:0]       query_index_1,
    input  logic [DEPTH-1:0]       query_index_2,
    output logic                   query_busy_1,
    output logic                   query_busy_2,
    output logic                   rf_write_enable,
    output logic [DEPTH-1:0]       rf_write_index,
    output logic [WIDTH-1:0]       rf_write_data
);

    localparam int NREG = 1 << DEPTH;

    logic [N_REQ-1:0] grant;
    logic             any_grant;
    logic [DEPTH-1:0] win_index;
    logic [WIDTH-1:0] win_data;

    logic             rf_we_q;
    logic [DEPTH-1:0] rf_index_q;
    logic [WIDTH-1:0] rf_data_q;

    logic [NREG-1:0]  busy_q, busy_d;

    assign any_grant = |grant;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_valid),
        .advance_i (any_grant),
        .grant_o   (grant)
    );

    assign req_ready = grant;

    always_comb begin
        win_index = '0;
        win_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                win_index = req_index[k*DEPTH +: DEPTH];
                win_data  = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Writes to register 0 are acknowledged but never reach the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_index_q <= '0;
            rf_data_q  <= '0;
        end else begin
            rf_we_q <= any_grant && (win_index != '0);
            if (any_grant) begin
                rf_index_q <= win_index;
                rf_data_q  <= win_data;
            end
        end
    end

    assign rf_write_enable = rf_we_q;
    assign rf_write_index  = rf_index_q;
    assign rf_write_data   = rf_data_q;

    assign reserve_ready = (reserve_index == '0) || !busy_q[reserve_index];

    // Clear first so a same-cycle reservation of the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_index_q] = 1'b0;
        end
        if (reserve_valid && reserve_ready && (reserve_index != '0)) begin
            busy_d[reserve_index] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign query_busy_1 = busy_q[query_index_1];
    assign query_busy_2 = busy_q[query_index_2];

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Directed bench for register_writeback_arbiter: a per-cycle reference model plus
// literal expectations taken from the intended behaviour of each scenario.
module tb_register_writeback_arbiter;

    localparam int W  = 32;
    localparam int D  = 5;
    localparam int NR = 3;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*D-1:0] req_index;
    logic [NR*W-1:0] req_data;
    logic            reserve_valid;
    logic [D-1:0]    reserve_index;
    logic            reserve_ready;
    logic [D-1:0]    query_index_1, query_index_2;
    logic            query_busy_1, query_busy_2;
    logic            rf_write_enable;
    logic [D-1:0]    rf_write_index;
    logic [W-1:0]    rf_write_data;

    int vectors     = 0;
    int miscompares = 0;
    int rst_events  = 0;
    int rst_handled = 0;

    register_writeback_arbiter #(.WIDTH(W), .DEPTH(D), .N_REQ(NR)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_index       (req_index),
        .req_data        (req_data),
        .reserve_valid   (reserve_valid),
        .reserve_index   (reserve_index),
        .reserve_ready   (reserve_ready),
        .query_index_1   (query_index_1),
        .query_index_2   (query_index_2),
        .query_busy_1    (query_busy_1),
        .query_busy_2    (query_busy_2),
        .rf_write_enable (rf_write_enable),
        .rf_write_index  (rf_write_index),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state only.
    int        m_ptr;
    bit        m_busy [32];
    bit        m_we;
    int        m_idx;
    logic [W-1:0] m_data;

    always @(posedge reset) rst_events++;

    always @(negedge clk) begin
        int win;
        int j;
        logic [NR-1:0] exp_ready;
        bit exp_rr;
        if (reset || rst_events != rst_handled) begin
            m_ptr = 0; m_we = 0; m_idx = 0; m_data = '0;
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            rst_handled = rst_events;
        end
        win = -1;
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                j = (m_ptr + i) % NR;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_rr = (reserve_index == 0) || !m_busy[reserve_index];

        chk("model req_ready", 64'(req_ready), 64'(exp_ready));
        chk("model rf_we", 64'(rf_write_enable), 64'(m_we));
        chk("model rf_index", 64'(rf_write_index), 64'(m_idx));
        chk("model rf_data", 64'(rf_write_data), 64'(m_data));
        chk("model reserve_ready", 64'(reserve_ready), 64'(exp_rr));
        chk("model query_busy_1", 64'(query_busy_1), 64'(m_busy[query_index_1]));
        chk("model query_busy_2", 64'(query_busy_2), 64'(m_busy[query_index_2]));

        if (!reset) begin
            if (m_we) m_busy[m_idx] = 0;
            if (reserve_valid && exp_rr && reserve_index != 0) m_busy[reserve_index] = 1;
            if (win >= 0) begin
                m_idx  = int'(req_index[win*D +: D]);
                m_data = req_data[win*W +: W];
                m_we   = (m_idx != 0);
                m_ptr  = (win + 1) % NR;
            end else begin
                m_we = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [D-1:0] idx, input logic [W-1:0] data);
        req_index[k*D +: D] = idx;
        req_data[k*W +: W]  = data;
    endtask

    initial begin
        logic [NR-1:0] order [6];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
        order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;

        reset = 1'b1;
        req_valid = '0; req_index = '0; req_data = '0;
        reserve_valid = 1'b0; reserve_index = '0;
        query_index_1 = '0; query_index_2 = '0;
        repeat (3) tick();
        settle();
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rf_we", 64'(rf_write_enable), 64'd0);
        chk("reset rf_data", 64'(rf_write_data), 64'd0);
        tick();
        reset = 1'b0;

        // Single ALU write.
        req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
        settle();
        chk("alu req_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        settle();
        chk("alu rf_we", 64'(rf_write_enable), 64'h1);
        chk("alu rf_index", 64'(rf_write_index), 64'd5);
        chk("alu rf_data", 64'(rf_write_data), 64'hDEADBEEF);

        // Bring pointer back to 0, then all three contend.
        tick();
        req_valid = 3'b100; set_req(2, 5'd3, 32'h3333_0000);
        settle();
        chk("wrap req_ready", 64'(req_ready), 64'h4);
        tick();
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("rr grant order", 64'(req_ready), 64'(order[c]));
            if (c > 0) chk("rr rf_we", 64'(rf_write_enable), 64'h1);
            tick();
        end
        req_valid = '0;
        settle();
        chk("rr last rf_index", 64'(rf_write_index), 64'd3);

        // Reserve 7, second claim blocked, load retires 7.
        tick();
        reserve_valid = 1'b1; reserve_index = 5'd7; query_index_1 = 5'd7;
        settle();
        chk("res7 ready", 64'(reserve_ready), 64'h1);
        chk("res7 busy before", 64'(query_busy_1), 64'h0);
        tick();
        settle();
        chk("res7 busy after", 64'(query_busy_1), 64'h1);
        chk("res7 second claim", 64'(reserve_ready), 64'h0);
        tick();
        reserve_valid = 1'b0;
        req_valid = 3'b010; set_req(1, 5'd7, 32'h0000_0077);
        settle();
        chk("load7 req_ready", 64'(req_ready), 64'h2);
        chk("load7 busy grant cyc", 64'(query_busy_1), 64'h1);
        tick();
        req_valid = '0;
        settle();
        chk("load7 rf_we", 64'(rf_write_enable), 64'h1);
        chk("load7 rf_index", 64'(rf_write_index), 64'd7);
        chk("load7 busy write cyc", 64'(query_busy_1), 64'h1);
        tick();
        settle();
        chk("load7 busy freed", 64'(query_busy_1), 64'h0);

        // Write to register 0.
        tick();
        req_valid = 3'b001; set_req(0, 5'd0, 32'h0000_1234);
        reserve_valid = 1'b1; reserve_index = 5'd0; query_index_2 = 5'd0;
        settle();
        chk("r0 req_ready", 64'(req_ready), 64'h1);
        chk("r0 reserve_ready", 64'(reserve_ready), 64'h1);
        tick();
        req_valid = '0; reserve_valid = 1'b0;
        settle();
        chk("r0 rf_we", 64'(rf_write_enable), 64'h0);
        chk("r0 busy", 64'(query_busy_2), 64'h0);

        // Reserve 9 in the cycle its write reaches the register file.
        tick();
        req_valid = 3'b001; set_req(0, 5'd9, 32'h0000_9999); query_index_1 = 5'd9;
        settle();
        chk("r9 req_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0; reserve_valid = 1'b1; reserve_index = 5'd9;
        settle();
        chk("r9 rf_we", 64'(rf_write_enable), 64'h1);
        chk("r9 reserve_ready", 64'(reserve_ready), 64'h1);
        tick();
        reserve_valid = 1'b0;
        settle();
        chk("r9 set wins", 64'(query_busy_1), 64'h1);

        // Reset with an in-flight write and busy bits 3 and 9.
        tick();
        reserve_valid = 1'b1; reserve_index = 5'd3;
        req_valid = 3'b010; set_req(1, 5'd5, 32'h0000_5555);
        tick();
        reserve_valid = 1'b0; req_valid = '0;
        query_index_1 = 5'd3; query_index_2 = 5'd9;
        settle();
        chk("pre-rst rf_we", 64'(rf_write_enable), 64'h1);
        chk("pre-rst busy3", 64'(query_busy_1), 64'h1);
        chk("pre-rst busy9", 64'(query_busy_2), 64'h1);
        reset = 1'b1; req_valid = 3'b111;
        #1;
        chk("rst rf_we", 64'(rf_write_enable), 64'h0);
        chk("rst rf_index", 64'(rf_write_index), 64'h0);
        chk("rst rf_data", 64'(rf_write_data), 64'h0);
        chk("rst req_ready", 64'(req_ready), 64'h0);
        chk("rst busy3", 64'(query_busy_1), 64'h0);
        chk("rst busy9", 64'(query_busy_2), 64'h0);
        tick();
        reset = 1'b0;
        settle();
        chk("post-rst grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
